pu_feeder: RTL and testbench



---
 rtl/pu_pkg.sv | 24 ++
 rtl/pu_feed_addr_gen.sv | 52 +++++
 rtl/pu_feeder.sv | 141 ++++++++++++++
 tb/tb_pu_feeder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pu_pkg.sv
// rtl/pu_pkg.sv - shared types and sizing helpers for the PU feeder
package pu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } pu_state_e;

    localparam int MAC_LAT_DEF    = 2;
    localparam int ADDR_WIDTH_DEF = 6;

    // Length field is one bit wider than the address so K_MAX itself is representable.
    function automatic int len_width(input int aw);
        return aw + 1;
    endfunction

    function automatic int k_max(input int aw);
        return 2 ** aw;
    endfunction

endpackage

// File: rtl/pu_feed_addr_gen.sv
// rtl/pu_feed_addr_gen.sv - beat counter and modulo buffer address generation
module pu_feed_addr_gen #(
    parameter int ADDR_WIDTH = 6,
    parameter int LW         = 7
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  hold_i,
    input  logic                  load_i,
    input  logic                  inc_i,
    input  logic [ADDR_WIDTH-1:0] x_base_i,
    input  logic [ADDR_WIDTH-1:0] w_base_i,
    output logic [LW-1:0]         cnt_o,
    output logic [ADDR_WIDTH-1:0] x_addr_o,
    output logic [ADDR_WIDTH-1:0] w_addr_o
);

    logic [LW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] x_base_q, x_base_d;
    logic [ADDR_WIDTH-1:0] w_base_q, w_base_d;

    always_comb begin
        cnt_d    = cnt_q;
        x_base_d = x_base_q;
        w_base_d = w_base_q;
        if (load_i) begin
            cnt_d    = '0;
            x_base_d = x_base_i;
            w_base_d = w_base_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q    <= '0;
            x_base_q <= '0;
            w_base_q <= '0;
        end else if (!hold_i) begin
            cnt_q    <= cnt_d;
            x_base_q <= x_base_d;
            w_base_q <= w_base_d;
        end
    end

    // Address arithmetic truncates to ADDR_WIDTH, so reads wrap around the buffer.
    assign x_addr_o = x_base_q + cnt_q[ADDR_WIDTH-1:0];
    assign w_addr_o = w_base_q + cnt_q[ADDR_WIDTH-1:0];
    assign cnt_o    = cnt_q;

endmodule

// File: rtl/pu_feeder.sv
// rtl/pu_feeder.sv - processing-unit pass sequencer; PU_FEEDER_ZERO_SKIP_EN enables zero-weight skip
module pu_feeder
    import pu_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int MAC_NUM      = 8,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int MAC_LAT      = MAC_LAT_DEF
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          start_i,
    input  logic [ADDR_WIDTH:0]           k_len_i,
    input  logic [ADDR_WIDTH-1:0]         x_base_i,
    input  logic [ADDR_WIDTH-1:0]         w_base_i,
    input  logic                          hold_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          x_rd_en_o,
    output logic                          w_rd_en_o,
    output logic [ADDR_WIDTH-1:0]         x_addr_o,
    output logic [ADDR_WIDTH-1:0]         w_addr_o,
    input  logic [DATA_WIDTH*MAC_NUM-1:0] x_rdata_i,
    input  logic [WEIGHT_WIDTH-1:0]       w_rdata_i,
    output logic                          pu_en_o,
    output logic                          pu_valid_o,
    output logic                          pu_clear_o,
    output logic                          pu_done_o,
    output logic [DATA_WIDTH*MAC_NUM-1:0] pu_din_o,
    output logic [WEIGHT_WIDTH-1:0]       pu_win_o
);

    localparam int LW    = len_width(ADDR_WIDTH);
    localparam int K_MAX = k_max(ADDR_WIDTH);
    localparam int DW    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    pu_state_e     state_q, state_d;
    logic [LW-1:0] k_q, k_d;
    logic [DW-1:0] drn_q, drn_d;
    logic [LW-1:0] cnt;
    logic          load, inc, rd_en, clr, vld, dn, beat_live, run;

    pu_feed_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LW         (LW)
    ) u_addr_gen (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .hold_i   (hold_i),
        .load_i   (load),
        .inc_i    (inc),
        .x_base_i (x_base_i),
        .w_base_i (w_base_i),
        .cnt_o    (cnt),
        .x_addr_o (x_addr_o),
        .w_addr_o (w_addr_o)
    );

    // In FEED, cnt counts beats issued; the beat presented this cycle is cnt-1.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        drn_d   = drn_q;
        load    = 1'b0;
        inc     = 1'b0;
        rd_en   = 1'b0;
        clr     = 1'b0;
        vld     = 1'b0;
        dn      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    k_d     = (k_len_i > LW'(K_MAX)) ? LW'(K_MAX) : k_len_i;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clr   = 1'b1;
                drn_d = '0;
                if (k_q != '0) begin
                    rd_en   = 1'b1;
                    inc     = 1'b1;
                    state_d = ST_FEED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FEED: begin
                vld = 1'b1;
                if (cnt < k_q) begin
                    rd_en = 1'b1;
                    inc   = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drn_q == DW'(MAC_LAT - 1)) state_d = ST_DONE;
                else                           drn_d   = drn_q + 1'b1;
            end
            ST_DONE: begin
                dn      = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            drn_q   <= '0;
        end else if (!hold_i) begin
            state_q <= state_d;
            k_q     <= k_d;
            drn_q   <= drn_d;
        end
    end

`ifdef PU_FEEDER_ZERO_SKIP_EN
    assign beat_live = (w_rdata_i != '0);
`else
    assign beat_live = 1'b1;
`endif

    assign run        = !hold_i;
    assign busy_o     = (state_q != ST_IDLE);
    assign x_rd_en_o  = rd_en & run;
    assign w_rd_en_o  = rd_en & run;
    assign pu_en_o    = busy_o & run;
    assign pu_clear_o = clr & run;
    assign pu_valid_o = vld & beat_live & run;
    assign pu_done_o  = dn & run;
    assign done_o     = dn & run;
    assign pu_din_o   = (state_q == ST_FEED) ? x_rdata_i : '0;
    assign pu_win_o   = (state_q == ST_FEED) ? w_rdata_i : '0;

endmodule

// File: tb/tb_pu_feeder.sv
// tb/tb_pu_feeder.sv - directed vector bench for pu_feeder
module tb_pu_feeder;

`ifdef PU_FEEDER_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  k_len = '0;
    logic [5:0]  x_base = '0;
    logic [5:0]  w_base = '0;
    logic        hold = 1'b0;
    logic        busy, done, x_rd_en, w_rd_en, pu_en, pu_valid, pu_clear, pu_done;
    logic [5:0]  x_addr, w_addr;
    logic [63:0] x_rdata = '0;
    logic [7:0]  w_rdata = '0;
    logic [63:0] pu_din;
    logic [7:0]  pu_win;

    logic [63:0] x_mem [64];
    logic [7:0]  w_mem [64];

    int napplied = 0;
    int nmis = 0;

    typedef struct {
        int k;
        int xb;
        int wb;
        int hlo;
        int hhi;
        int e_clr;
        int e_first;
        int e_last;
        int e_done;
        int e_nv;
    } vec_t;

    vec_t vt [8];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (x_rd_en) x_rdata <= x_mem[x_addr];
        if (w_rd_en) w_rdata <= w_mem[w_addr];
    end

    pu_feeder dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .start_i    (start),
        .k_len_i    (k_len),
        .x_base_i   (x_base),
        .w_base_i   (w_base),
        .hold_i     (hold),
        .busy_o     (busy),
        .done_o     (done),
        .x_rd_en_o  (x_rd_en),
        .w_rd_en_o  (w_rd_en),
        .x_addr_o   (x_addr),
        .w_addr_o   (w_addr),
        .x_rdata_i  (x_rdata),
        .w_rdata_i  (w_rdata),
        .pu_en_o    (pu_en),
        .pu_valid_o (pu_valid),
        .pu_clear_o (pu_clear),
        .pu_done_o  (pu_done),
        .pu_din_o   (pu_din),
        .pu_win_o   (pu_win)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        napplied++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [91:0] act, input logic [91:0] exp);
        napplied++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        logic [91:0] o;
        o = {busy, done, x_rd_en, w_rd_en, x_addr, w_addr, pu_en, pu_valid,
             pu_clear, pu_done, pu_din, pu_win};
        chk_w(name, o, '0);
    endtask

    task automatic run_pass(input int vi, input vec_t v);
        int cyc, clr_c, first_v, last_v, nv, busy_n, quiet_bad, bi, done_c, pdone_bad;
        logic [91:0] exp_beat;
        clr_c = 0; first_v = 0; last_v = 0; nv = 0; busy_n = 0;
        quiet_bad = 0; bi = 0; done_c = 0; pdone_bad = 0;
        @(negedge clk);
        start  = 1'b1;
        k_len  = 7'(v.k);
        x_base = 6'(v.xb);
        w_base = 6'(v.wb);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (done_c == 0 && cyc <= 200) begin
            hold = (v.hhi != 0 && cyc >= v.hlo && cyc <= v.hhi);
            @(negedge clk);
            if (busy) busy_n++;
            if (hold && (x_rd_en | w_rd_en | pu_en | pu_valid | pu_clear | pu_done | done))
                quiet_bad++;
            if (pu_done != done) pdone_bad++;
            if (pu_clear && clr_c == 0) clr_c = cyc;
            if (pu_valid) begin
                if (first_v == 0) first_v = cyc;
                last_v = cyc;
                nv++;
                while (ZS && bi < 63 && w_mem[(v.wb + bi) % 64] == 8'd0) bi++;
                exp_beat = {20'd0, x_mem[(v.xb + bi) % 64], w_mem[(v.wb + bi) % 64]};
                chk_w($sformatf("v%0d_beat%0d", vi, bi), {20'd0, pu_din, pu_win}, exp_beat);
                bi++;
            end
            if (done) done_c = cyc;
            @(posedge clk); #1;
            cyc++;
        end
        hold = 1'b0;
        chk($sformatf("v%0d_clear_cycle", vi), clr_c, v.e_clr);
        chk($sformatf("v%0d_done_cycle", vi), done_c, v.e_done);
        chk($sformatf("v%0d_valid_count", vi), nv, v.e_nv);
        chk($sformatf("v%0d_first_valid", vi), first_v, v.e_first);
        chk($sformatf("v%0d_last_valid", vi), last_v, v.e_last);
        chk($sformatf("v%0d_busy_cycles", vi), busy_n, v.e_done);
        chk($sformatf("v%0d_hold_quiet", vi), quiet_bad, 0);
        chk($sformatf("v%0d_pu_done_match", vi), pdone_bad, 0);
        @(negedge clk);
        chk($sformatf("v%0d_idle_after", vi), {busy, done, pu_en}, 3'b000);
    endtask

    initial begin
        int dn_seen;
        for (int i = 0; i < 64; i++) begin
            x_mem[i] = {8{8'(i * 3 + 1)}} ^ 64'h0123_4567_89AB_CDEF;
            w_mem[i] = 8'((i % 7) + 1);
        end
        //          k   xb  wb  hlo hhi clr first last done nv
        vt[0] = '{  4,  0,  0,  0,  0,  1,  2,   5,   8,  4};
        vt[1] = '{  0,  0,  0,  0,  0,  1,  0,   0,   4,  0};
        vt[2] = '{  4, 62, 10,  0,  0,  1,  2,   5,   8,  4};
        vt[3] = '{  4,  0,  0,  3,  4,  1,  2,   7,  10,  4};
        vt[4] = '{100,  5, 33,  0,  0,  1,  2,  65,  68, 64};
        vt[5] = '{  1, 63, 63,  0,  0,  1,  2,   2,   5,  1};
        vt[6] = '{  2,  0,  0,  1,  1,  2,  3,   4,   7,  2};
        vt[7] = '{  4,  0, 20,  0,  0,  1,  2,   5,   8,  ZS ? 2 : 4};

        repeat (2) @(negedge clk);
        check_zero("reset_state");
        @(posedge clk); #1;
        rstn = 1'b1;

        for (int i = 0; i < 7; i++) run_pass(i, vt[i]);

        // Reset in cycle 3 of a pass: outputs drop at once and no done follows.
        @(negedge clk);
        start = 1'b1; k_len = 7'd4; x_base = 6'd7; w_base = 6'd9;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        check_zero("mid_pass_reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        dn_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy || pu_done) dn_seen++;
        end
        chk("no_done_after_abort", dn_seen, 0);
        run_pass(8, vt[0]);

        w_mem[20] = 8'd5; w_mem[21] = 8'd0; w_mem[22] = 8'd0; w_mem[23] = 8'd7;
        run_pass(7, vt[7]);

        $display("== %0d vectors applied, %0d miscompares ==", napplied, nmis);
        $finish;
    end

endmodule
